// File: rtl/rob_pkg.sv
// Shared types and constants for the reorder-buffer controller.
// Pointers carry a wrap bit above the index so full and empty can be told apart.
package rob_pkg;

    localparam int unsigned ROB_ENTRIES = 64;
    localparam int unsigned ROB_IDX_W   = $clog2(ROB_ENTRIES);
    localparam int unsigned ROB_PTR_W   = ROB_IDX_W + 1;

    typedef logic [ROB_IDX_W-1:0] rob_idx_t;
    typedef logic [ROB_IDX_W:0]   rob_cnt_t;

    typedef struct packed {
        logic     wrap;
        rob_idx_t idx;
    } rob_ptr_t;

    typedef struct packed {
        logic valid;
        logic done;
        logic exc;
    } rob_status_t;

    // With a power-of-two depth, plain wide addition wraps the index and toggles the wrap bit.
    function automatic rob_ptr_t rob_ptr_inc(input rob_ptr_t p);
        return rob_ptr_t'(rob_cnt_t'(p) + rob_cnt_t'(1));
    endfunction

    function automatic rob_cnt_t rob_ptr_diff(input rob_ptr_t a, input rob_ptr_t b);
        return rob_cnt_t'(rob_cnt_t'(a) - rob_cnt_t'(b));
    endfunction

endpackage

// File: rtl/rob_ctrl_if.sv
// Dispatch / writeback / retire signal bundle for the ROB controller.
// The controller uses the slave modport; the surrounding pipeline uses master.
interface rob_ctrl_if;
    import rob_pkg::*;

    logic     alloc_req;
    logic     alloc_rdy;
    rob_idx_t alloc_idx;

    logic     wb_valid;
    rob_idx_t wb_idx;
    logic     wb_exc;

    logic     commit_valid;
    rob_idx_t commit_idx;
    logic     commit_rdy;

    logic     flush;
    rob_idx_t flush_idx;

    rob_cnt_t count;
    logic     full;
    logic     empty;

    modport slave (
        input  alloc_req,
        output alloc_rdy,
        output alloc_idx,
        input  wb_valid,
        input  wb_idx,
        input  wb_exc,
        output commit_valid,
        output commit_idx,
        input  commit_rdy,
        output flush,
        output flush_idx,
        output count,
        output full,
        output empty
    );

    modport master (
        output alloc_req,
        input  alloc_rdy,
        input  alloc_idx,
        output wb_valid,
        output wb_idx,
        output wb_exc,
        input  commit_valid,
        input  commit_idx,
        output commit_rdy,
        input  flush,
        input  flush_idx,
        input  count,
        input  full,
        input  empty
    );

endinterface

// File: rtl/rob_ptr.sv
// Wrap-bit circular pointer register; clear has priority over increment.
module rob_ptr
    import rob_pkg::*;
(
    input  logic     clk,
    input  logic     rst_n,
    input  logic     i_inc,
    input  logic     i_clr,
    output rob_ptr_t o_ptr
);

    rob_ptr_t r_ptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= '0;
        end else if (i_clr) begin
            r_ptr <= '0;
        end else if (i_inc) begin
            r_ptr <= rob_ptr_inc(r_ptr);
        end
    end

    assign o_ptr = r_ptr;

endmodule

// File: rtl/rob_ctrl.sv
// Reorder-buffer allocation/commit controller: owns head/tail and per-entry status,
// allocates at tail, marks entries done at writeback, retires in order, flushes on exception.
module rob_ctrl
    import rob_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    rob_ctrl_if.slave  bus
);

    rob_ptr_t    w_head;
    rob_ptr_t    w_tail;
    rob_status_t r_status [ROB_ENTRIES];
    rob_status_t w_head_st;

    logic w_full;
    logic w_empty;
    logic w_flush;
    logic w_commit_valid;
    logic w_alloc_rdy;
    logic w_alloc_fire;
    logic w_commit_fire;
    logic w_wb_fire;

    assign w_head_st = r_status[w_head.idx];

    assign w_full  = (w_head.idx == w_tail.idx) && (w_head.wrap != w_tail.wrap);
    assign w_empty = (w_head == w_tail);

    // Head-of-buffer decisions are made purely from registered status.
    assign w_flush        = w_head_st.valid &  w_head_st.done &  w_head_st.exc;
    assign w_commit_valid = w_head_st.valid &  w_head_st.done & ~w_head_st.exc;

    // No bypass: a commit in the same cycle does not open a slot for a full buffer.
    assign w_alloc_rdy   = ~w_full & ~w_flush;
    assign w_alloc_fire  = bus.alloc_req & w_alloc_rdy;
    assign w_commit_fire = w_commit_valid & bus.commit_rdy;
    assign w_wb_fire     = bus.wb_valid & r_status[bus.wb_idx].valid & ~w_flush;

    rob_ptr u_head_ptr (
        .clk   (clk),
        .rst_n (rst_n),
        .i_inc (w_commit_fire),
        .i_clr (w_flush),
        .o_ptr (w_head)
    );

    rob_ptr u_tail_ptr (
        .clk   (clk),
        .rst_n (rst_n),
        .i_inc (w_alloc_fire),
        .i_clr (w_flush),
        .o_ptr (w_tail)
    );

    // Status flops; flush clears every entry in parallel, which is why this is not a RAM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(ROB_ENTRIES); i++) begin
                r_status[i] <= '0;
            end
        end else if (w_flush) begin
            for (int i = 0; i < int'(ROB_ENTRIES); i++) begin
                r_status[i] <= '0;
            end
        end else begin
            if (w_wb_fire) begin
                r_status[bus.wb_idx].done <= 1'b1;
                r_status[bus.wb_idx].exc  <= bus.wb_exc;
            end
            if (w_alloc_fire) begin
                r_status[w_tail.idx] <= '{valid: 1'b1, done: 1'b0, exc: 1'b0};
            end
            if (w_commit_fire) begin
                r_status[w_head.idx] <= '0;
            end
        end
    end

    assign bus.alloc_rdy    = w_alloc_rdy;
    assign bus.alloc_idx    = w_tail.idx;
    assign bus.commit_valid = w_commit_valid;
    assign bus.commit_idx   = w_head.idx;
    assign bus.flush        = w_flush;
    assign bus.flush_idx    = w_head.idx;
    assign bus.count        = rob_ptr_diff(w_tail, w_head);
    assign bus.full         = w_full;
    assign bus.empty        = w_empty;

endmodule

// File: tb/tb_rob_ctrl.sv
// Directed bench for rob_ctrl: allocation, in-order commit, full/wrap,
// exception flush, steady-state streaming and asynchronous reset.
module tb_rob_ctrl;
    import rob_pkg::*;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    rob_ctrl_if bus ();

    rob_ctrl u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.alloc_req  = 1'b0;
        bus.wb_valid   = 1'b0;
        bus.wb_idx     = '0;
        bus.wb_exc     = 1'b0;
        bus.commit_rdy = 1'b0;
    endtask

    initial begin
        int h;
        int t;
        idle();
        rst_n = 1'b0;
        #12;
        check_eq("rst_empty",     32'(bus.empty),        1);
        check_eq("rst_full",      32'(bus.full),         0);
        check_eq("rst_alloc_rdy", 32'(bus.alloc_rdy),    1);
        check_eq("rst_cvalid",    32'(bus.commit_valid), 0);
        check_eq("rst_flush",     32'(bus.flush),        0);
        check_eq("rst_alloc_idx", 32'(bus.alloc_idx),    0);
        check_eq("rst_count",     32'(bus.count),        0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // three allocations
        for (int i = 0; i < 3; i++) begin
            bus.alloc_req = 1'b1;
            check_eq("t1_alloc_idx", 32'(bus.alloc_idx), 32'(i));
            tick();
        end
        bus.alloc_req = 1'b0;
        check_eq("t1_count",  32'(bus.count),        3);
        check_eq("t1_cvalid", 32'(bus.commit_valid), 0);
        check_eq("t1_empty",  32'(bus.empty),        0);

        // out-of-order writeback, in-order commit
        bus.wb_valid = 1'b1;
        bus.wb_idx   = ROB_IDX_W'(1);
        tick();
        check_eq("t2_cvalid_idx1_only", 32'(bus.commit_valid), 0);
        bus.wb_idx = ROB_IDX_W'(0);
        check_eq("t2_cvalid_same_cycle", 32'(bus.commit_valid), 0);
        tick();
        bus.wb_valid = 1'b0;
        check_eq("t2_cvalid_head0", 32'(bus.commit_valid), 1);
        check_eq("t2_cidx_head0",   32'(bus.commit_idx),   0);
        tick();
        check_eq("t2_stall_cvalid", 32'(bus.commit_valid), 1);
        check_eq("t2_stall_cidx",   32'(bus.commit_idx),   0);
        check_eq("t2_stall_count",  32'(bus.count),        3);
        bus.commit_rdy = 1'b1;
        tick();
        check_eq("t2_cidx_1",   32'(bus.commit_idx),   1);
        check_eq("t2_cvalid_1", 32'(bus.commit_valid), 1);
        tick();
        bus.commit_rdy = 1'b0;
        check_eq("t2_cvalid_2", 32'(bus.commit_valid), 0);
        check_eq("t2_cidx_2",   32'(bus.commit_idx),   2);
        check_eq("t2_count",    32'(bus.count),        1);

        // exception at head -> one-cycle flush; alloc in that cycle is dropped
        bus.wb_valid = 1'b1;
        bus.wb_idx   = ROB_IDX_W'(2);
        bus.wb_exc   = 1'b1;
        tick();
        bus.wb_exc    = 1'b0;
        bus.alloc_req = 1'b1;
        check_eq("t4_flush",     32'(bus.flush),        1);
        check_eq("t4_flush_idx", 32'(bus.flush_idx),    2);
        check_eq("t4_cvalid",    32'(bus.commit_valid), 0);
        check_eq("t4_alloc_rdy", 32'(bus.alloc_rdy),    0);
        tick();
        idle();
        check_eq("t4_flush_after", 32'(bus.flush),      0);
        check_eq("t4_empty",       32'(bus.empty),      1);
        check_eq("t4_count",       32'(bus.count),      0);
        check_eq("t4_tail",        32'(bus.alloc_idx),  0);
        check_eq("t4_head",        32'(bus.commit_idx), 0);
        tick();
        check_eq("t4_still_empty", 32'(bus.empty),      1);

        // fill to full, then commit one and allocate into the wrapped slot
        for (int i = 0; i < int'(ROB_ENTRIES); i++) begin
            bus.alloc_req = 1'b1;
            if (i == int'(ROB_ENTRIES) - 1) check_eq("t3_last_idx", 32'(bus.alloc_idx), 63);
            tick();
        end
        check_eq("t3_full",      32'(bus.full),      1);
        check_eq("t3_alloc_rdy", 32'(bus.alloc_rdy), 0);
        check_eq("t3_count",     32'(bus.count),     64);
        check_eq("t3_tail_wrap", 32'(bus.alloc_idx), 0);
        tick();
        check_eq("t3_count_held", 32'(bus.count), 64);
        bus.alloc_req = 1'b0;
        bus.wb_valid  = 1'b1;
        bus.wb_idx    = ROB_IDX_W'(0);
        tick();
        bus.wb_valid   = 1'b0;
        bus.alloc_req  = 1'b1;
        bus.commit_rdy = 1'b1;
        check_eq("t3_cvalid",       32'(bus.commit_valid), 1);
        check_eq("t3_no_bypass",    32'(bus.alloc_rdy),    0);
        tick();
        bus.commit_rdy = 1'b0;
        check_eq("t3_count_63",     32'(bus.count),      63);
        check_eq("t3_rdy_again",    32'(bus.alloc_rdy),  1);
        check_eq("t3_alloc_idx0",   32'(bus.alloc_idx),  0);
        check_eq("t3_not_full",     32'(bus.full),       0);
        check_eq("t3_head1",        32'(bus.commit_idx), 1);
        tick();
        bus.alloc_req = 1'b0;
        check_eq("t3_count_64",     32'(bus.count),     64);
        check_eq("t3_full_again",   32'(bus.full),      1);
        check_eq("t3_tail1",        32'(bus.alloc_idx), 1);

        // restart from reset, pre-load four done entries
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        check_eq("t5_empty", 32'(bus.empty), 1);
        bus.alloc_req = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        bus.alloc_req = 1'b0;
        bus.wb_valid  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.wb_idx = ROB_IDX_W'(i);
            tick();
        end
        bus.wb_valid = 1'b0;

        // steady alloc + commit, writing back the entry allocated one cycle earlier
        for (int k = 0; k < 200; k++) begin
            h = k % 64;
            t = (k + 4) % 64;
            bus.alloc_req  = 1'b1;
            bus.commit_rdy = 1'b1;
            bus.wb_valid   = 1'b1;
            bus.wb_idx     = ROB_IDX_W'((t + 63) % 64);
            check_eq("t5_count",  32'(bus.count),        4);
            check_eq("t5_cvalid", 32'(bus.commit_valid), 1);
            check_eq("t5_head",   32'(bus.commit_idx),   32'(h));
            check_eq("t5_tail",   32'(bus.alloc_idx),    32'(t));
            tick();
        end
        idle();
        check_eq("t5_end_count", 32'(bus.count),      4);
        check_eq("t5_end_head",  32'(bus.commit_idx), 8);
        check_eq("t5_end_tail",  32'(bus.alloc_idx),  12);

        // async reset mid-stream with ten entries in flight
        bus.alloc_req = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        bus.alloc_req = 1'b0;
        check_eq("t6_count10", 32'(bus.count), 10);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("t6_count",     32'(bus.count),        0);
        check_eq("t6_empty",     32'(bus.empty),        1);
        check_eq("t6_full",      32'(bus.full),         0);
        check_eq("t6_alloc_rdy", 32'(bus.alloc_rdy),    1);
        check_eq("t6_alloc_idx", 32'(bus.alloc_idx),    0);
        check_eq("t6_cvalid",    32'(bus.commit_valid), 0);
        check_eq("t6_flush",     32'(bus.flush),        0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
